// File: rtl/bounded_counter_if.sv
// ---------------------------------------------------------------------------
// bounded_counter_if
// Groups the control, limit and status signals of bounded_counter.
//   master : drives en, up, mode, load, load_val, lo_lim, hi_lim, step,
//            clr_flags; observes dout, at_max, at_min, wrap_pulse,
//            stopped, ovf_sticky, cfg_err
//   slave  : the counter itself (mirror directions)
// ---------------------------------------------------------------------------
interface bounded_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              up;
    logic [1:0]        mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  lo_lim;
    logic [WIDTH-1:0]  hi_lim;
    logic [STEP_W-1:0] step;
    logic              clr_flags;
    logic [WIDTH-1:0]  dout;
    logic              at_max;
    logic              at_min;
    logic              wrap_pulse;
    logic              stopped;
    logic              ovf_sticky;
    logic              cfg_err;

    modport master (
        output en, up, mode, load, load_val, lo_lim, hi_lim, step, clr_flags,
        input  dout, at_max, at_min, wrap_pulse, stopped, ovf_sticky, cfg_err
    );

    modport slave (
        input  en, up, mode, load, load_val, lo_lim, hi_lim, step, clr_flags,
        output dout, at_max, at_min, wrap_pulse, stopped, ovf_sticky, cfg_err
    );
endinterface

// File: rtl/bounded_counter.sv
// ---------------------------------------------------------------------------
// bounded_counter
// Up/down counter confined to [lo_lim, hi_lim] with selectable behaviour at
// the limits: saturate (mode 00/11), wrap to the opposite bound (mode 01) or
// one-shot halt (mode 10).
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : bounded_counter_if.slave
//          inputs  en, up, mode, load, load_val, lo_lim, hi_lim, step,
//                  clr_flags
//          outputs dout, wrap_pulse, stopped, ovf_sticky (registered);
//                  at_max, at_min, cfg_err (combinational)
// Per-cycle priority: cfg_err hold > load > out-of-range clamp > count > hold.
// ---------------------------------------------------------------------------
module bounded_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    bounded_counter_if.slave bus
);

    localparam logic [1:0] MODE_SAT  = 2'b00;
    localparam logic [1:0] MODE_WRAP = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;

    logic [WIDTH-1:0] dout_r;
    logic             wrap_r;
    logic             stop_r;
    logic             ovf_r;

    logic [WIDTH-1:0] dout_nxt_s;
    logic             wrap_nxt_s;
    logic             stop_nxt_s;
    logic             ovf_nxt_s;

    logic             cfg_err_s;
    logic             out_of_range_s;
    logic             count_s;
    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   cand_up_s;
    logic [WIDTH:0]   cand_dn_s;
    logic             hit_s;
    logic [WIDTH-1:0] cand_val_s;
    logic [WIDTH-1:0] hit_bound_s;
    logic [WIDTH-1:0] opp_bound_s;

    // Clamp an arbitrary value into [lo, hi]; only used while lo <= hi.
    function automatic logic [WIDTH-1:0] clamp_val(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        logic [WIDTH-1:0] res;
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end else begin
            res = val;
        end
        return res;
    endfunction

    assign cfg_err_s      = (bus.lo_lim > bus.hi_lim);
    assign out_of_range_s = (dout_r > bus.hi_lim) || (dout_r < bus.lo_lim);
    // A zero step never moves the counter and therefore can never hit a limit.
    assign count_s        = bus.en && !stop_r && (|bus.step);
    assign step_ext_s     = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
    // One extra bit catches carry on the way up and borrow on the way down.
    assign cand_up_s      = {1'b0, dout_r} + step_ext_s;
    assign cand_dn_s      = {1'b0, dout_r} - step_ext_s;

    // Limit detection for the selected direction, plus the bounds involved.
    always_comb begin
        hit_s       = 1'b0;
        cand_val_s  = dout_r;
        hit_bound_s = bus.hi_lim;
        opp_bound_s = bus.lo_lim;
        if (bus.up) begin
            hit_s       = (cand_up_s > {1'b0, bus.hi_lim});
            cand_val_s  = cand_up_s[WIDTH-1:0];
            hit_bound_s = bus.hi_lim;
            opp_bound_s = bus.lo_lim;
        end else begin
            hit_s       = cand_dn_s[WIDTH] || (cand_dn_s[WIDTH-1:0] < bus.lo_lim);
            cand_val_s  = cand_dn_s[WIDTH-1:0];
            hit_bound_s = bus.lo_lim;
            opp_bound_s = bus.hi_lim;
        end
    end

    // Next-state selection following the per-cycle priority order.
    always_comb begin
        dout_nxt_s = dout_r;
        wrap_nxt_s = 1'b0;
        stop_nxt_s = stop_r;
        ovf_nxt_s  = ovf_r;
        if (cfg_err_s) begin
            // Inconsistent limits: everything frozen, including the sticky flag.
            dout_nxt_s = dout_r;
            stop_nxt_s = stop_r;
            ovf_nxt_s  = ovf_r;
        end else begin
            if (bus.clr_flags) begin
                ovf_nxt_s = 1'b0;
            end else begin
                ovf_nxt_s = ovf_r;
            end

            if (bus.load) begin
                dout_nxt_s = clamp_val(bus.load_val, bus.lo_lim, bus.hi_lim);
                stop_nxt_s = 1'b0;
            end else if (bus.en && out_of_range_s) begin
                // Pull a stray count back to the bound it violates; not a limit hit.
                if (dout_r > bus.hi_lim) begin
                    dout_nxt_s = bus.hi_lim;
                end else begin
                    dout_nxt_s = bus.lo_lim;
                end
            end else if (count_s) begin
                if (hit_s) begin
                    // A limit hit overrides a same-cycle clr_flags.
                    ovf_nxt_s = 1'b1;
                    case (bus.mode)
                        MODE_WRAP: begin
                            dout_nxt_s = opp_bound_s;
                            wrap_nxt_s = 1'b1;
                        end
                        MODE_ONE: begin
                            dout_nxt_s = hit_bound_s;
                            stop_nxt_s = 1'b1;
                        end
                        MODE_SAT: begin
                            dout_nxt_s = hit_bound_s;
                        end
                        default: begin
                            dout_nxt_s = hit_bound_s;
                        end
                    endcase
                end else begin
                    dout_nxt_s = cand_val_s;
                end
            end else begin
                dout_nxt_s = dout_r;
            end
        end
    end

    // State and registered outputs; reset is asynchronous, active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
            stop_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            dout_r <= dout_nxt_s;
            wrap_r <= wrap_nxt_s;
            stop_r <= stop_nxt_s;
            ovf_r  <= ovf_nxt_s;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.wrap_pulse = wrap_r;
    assign bus.stopped    = stop_r;
    assign bus.ovf_sticky = ovf_r;
    assign bus.cfg_err    = cfg_err_s;
    assign bus.at_max     = (dout_r == bus.hi_lim);
    assign bus.at_min     = (dout_r == bus.lo_lim);

endmodule

// File: tb/tb_bounded_counter.sv
// ---------------------------------------------------------------------------
// tb_bounded_counter
// Table-driven bench: each record holds one cycle of stimulus and the state
// expected after the following rising edge. Expectations are queued when the
// stimulus is driven and popped once the edge has happened. Reset behaviour
// is exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_bounded_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    typedef struct {
        logic              load;
        logic [WIDTH-1:0]  ld;
        logic              en;
        logic              up;
        logic [1:0]        mode;
        logic [WIDTH-1:0]  lo;
        logic [WIDTH-1:0]  hi;
        logic [STEP_W-1:0] step;
        logic              clr;
        logic [WIDTH-1:0]  e_dout;
        logic              e_wrap;
        logic              e_stop;
        logic              e_ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             wrap;
        logic             stop;
        logic             ovf;
        logic             cfg;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   vec_idx;
    vec_t tbl[$];
    exp_t sb[$];

    bounded_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    bounded_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(
        input logic load, input int ld, input logic en, input logic up,
        input int mode, input int lo, input int hi, input int step,
        input logic clr, input int d, input logic w, input logic s, input logic o
    );
        vec_t v;
        v.load   = load;
        v.ld     = ld[WIDTH-1:0];
        v.en     = en;
        v.up     = up;
        v.mode   = mode[1:0];
        v.lo     = lo[WIDTH-1:0];
        v.hi     = hi[WIDTH-1:0];
        v.step   = step[STEP_W-1:0];
        v.clr    = clr;
        v.e_dout = d[WIDTH-1:0];
        v.e_wrap = w;
        v.e_stop = s;
        v.e_ovf  = o;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        bus.load      = v.load;
        bus.load_val  = v.ld;
        bus.en        = v.en;
        bus.up        = v.up;
        bus.mode      = v.mode;
        bus.lo_lim    = v.lo;
        bus.hi_lim    = v.hi;
        bus.step      = v.step;
        bus.clr_flags = v.clr;
        sb.push_back('{v.e_dout, v.e_wrap, v.e_stop, v.e_ovf, (v.lo > v.hi), v.lo, v.hi});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", idx, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("dout",       idx, 32'(bus.dout),       32'(e.dout));
            check("wrap_pulse", idx, 32'(bus.wrap_pulse), 32'(e.wrap));
            check("stopped",    idx, 32'(bus.stopped),    32'(e.stop));
            check("ovf_sticky", idx, 32'(bus.ovf_sticky), 32'(e.ovf));
            check("cfg_err",    idx, 32'(bus.cfg_err),    32'(e.cfg));
            check("at_max",     idx, 32'(bus.at_max),     32'(e.dout == e.hi));
            check("at_min",     idx, 32'(bus.at_min),     32'(e.dout == e.lo));
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0; bus.up = 1'b1;
        bus.mode = 2'b00; bus.lo_lim = '0; bus.hi_lim = 8'd100; bus.step = 4'd1;
        bus.clr_flags = 1'b0;

        //       L  ld  en up md lo  hi  st clr | dout w s o
        // saturate
        tbl.push_back(mk(1, 18, 0, 1, 0, 10, 20, 3, 0,  18, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 0, 10, 20, 3, 0,  20, 0, 0, 1));
        tbl.push_back(mk(0,  0, 1, 1, 0, 10, 20, 3, 0,  20, 0, 0, 1));
        tbl.push_back(mk(0,  0, 0, 1, 0, 10, 20, 3, 1,  20, 0, 0, 0));
        // wrap up and down
        tbl.push_back(mk(1, 19, 0, 1, 1, 10, 20, 3, 0,  19, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 1, 10, 20, 3, 0,  10, 1, 0, 1));
        tbl.push_back(mk(0,  0, 0, 1, 1, 10, 20, 3, 0,  10, 0, 0, 1));
        tbl.push_back(mk(0,  0, 0, 1, 1, 10, 20, 3, 1,  10, 0, 0, 0));
        tbl.push_back(mk(1, 11, 0, 0, 1, 10, 20, 3, 0,  11, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 0, 1, 10, 20, 3, 0,  20, 1, 0, 1));
        tbl.push_back(mk(0,  0, 1, 0, 1, 10, 20, 3, 0,  17, 0, 0, 1));
        // one-shot
        tbl.push_back(mk(1,254, 0, 1, 2,  0,255, 1, 1, 254, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 2,  0,255, 1, 0, 255, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 2,  0,255, 1, 0, 255, 0, 1, 1));
        tbl.push_back(mk(0,  0, 1, 1, 2,  0,255, 1, 0, 255, 0, 1, 1));
        tbl.push_back(mk(0,  0, 1, 0, 2,  0,255, 1, 0, 255, 0, 1, 1));
        tbl.push_back(mk(1,  5, 0, 1, 2,  0,255, 1, 0,   5, 0, 0, 1));
        tbl.push_back(mk(0,  0, 1, 1, 2,  0,255, 1, 0,   6, 0, 0, 1));
        // cfg_err freeze (count, load and clr_flags all ignored)
        tbl.push_back(mk(0,  0, 1, 1, 0, 30, 20, 1, 0,   6, 0, 0, 1));
        tbl.push_back(mk(1, 25, 1, 1, 0, 30, 20, 1, 0,   6, 0, 0, 1));
        tbl.push_back(mk(0,  0, 1, 1, 0, 30, 20, 1, 1,   6, 0, 0, 1));
        // out-of-range clamp, then a hit while already at the bound
        tbl.push_back(mk(1, 25, 0, 1, 0,  0,255, 1, 1,  25, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 0,  0, 20, 1, 0,  20, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 0,  0, 20, 1, 0,  20, 0, 0, 1));
        // load beats count; hit beats clr_flags
        tbl.push_back(mk(1,250, 1, 1, 0,  0,200, 1, 0, 200, 0, 0, 1));
        tbl.push_back(mk(0,  0, 1, 1, 0,  0,200, 1, 1, 200, 0, 0, 1));
        tbl.push_back(mk(0,  0, 0, 1, 0,  0,200, 1, 1, 200, 0, 0, 0));
        // step 0 never moves nor hits, even at the bound
        tbl.push_back(mk(1,100, 0, 1, 0,  0,200, 0, 0, 100, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 0,  0,200, 0, 0, 100, 0, 0, 0));
        tbl.push_back(mk(1,200, 0, 1, 0,  0,200, 0, 0, 200, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 1, 0,  0,200, 0, 0, 200, 0, 0, 0));
        // borrow below zero saturates at lo; load below lo clamps; mode 11
        tbl.push_back(mk(1,  2, 0, 0, 0,  0,200, 5, 0,   2, 0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 0, 0,  0,200, 5, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 0, 1, 0, 50,200, 5, 0,  50, 0, 0, 1));
        tbl.push_back(mk(0,  0, 1, 1, 3, 50, 60,15, 0,  60, 0, 0, 1));
        // one-shot going down
        tbl.push_back(mk(1,  3, 0, 0, 2,  0,255, 4, 0,   3, 0, 0, 1));
        tbl.push_back(mk(0,  0, 1, 0, 2,  0,255, 4, 0,   0, 0, 1, 1));

        // Reset state, asserted between edges
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #2;
        check("rst_dout",  0, 32'(bus.dout),       32'd0);
        check("rst_wrap",  0, 32'(bus.wrap_pulse), 32'd0);
        check("rst_stop",  0, 32'(bus.stopped),    32'd0);
        check("rst_ovf",   0, 32'(bus.ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        vec_idx = 1;
        foreach (tbl[i]) begin
            apply(tbl[i], vec_idx);
            vec_idx++;
        end

        // Async reset in the middle of a wrap pulse
        apply(mk(1, 19, 0, 1, 1, 10, 20, 3, 0, 19, 0, 0, 1), 100);
        apply(mk(0,  0, 1, 1, 1, 10, 20, 3, 0, 10, 1, 0, 1), 101);
        #2;
        rst    = 1'b0;
        bus.en = 1'b0;
        #1;
        check("mid_rst_dout", 102, 32'(bus.dout),       32'd0);
        check("mid_rst_wrap", 102, 32'(bus.wrap_pulse), 32'd0);
        check("mid_rst_stop", 102, 32'(bus.stopped),    32'd0);
        check("mid_rst_ovf",  102, 32'(bus.ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        // First enabled edge after release clamps 0 up to lo=5, then counts
        apply(mk(0, 0, 1, 1, 1, 5, 20, 3, 0, 5, 0, 0, 0), 103);
        apply(mk(0, 0, 1, 1, 1, 5, 20, 3, 0, 8, 0, 0, 0), 104);

        if (sb.size() != 0) begin
            check("scoreboard_leftover", 105, 32'(sb.size()), 32'd0);
        end else begin
            check("scoreboard_drained", 105, 32'(sb.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
